// File: rtl/led_pulse_pkg.sv
// Shared constants for the LED pulse generator: FSM state encodings and
// default parameter values used by led_pulse_gen and tick_div.
package led_pulse_pkg;

    localparam int unsigned DIV_DEF       = 4;
    localparam int unsigned ON_TICKS_DEF  = 2;
    localparam int unsigned OFF_TICKS_DEF = 1;
    localparam int unsigned PEND_W_DEF    = 2;

    // State encoding (IDLE / ON / GAP)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/tick_div.sv
// Slow-tick divider: counts 0..DIV-1 and flags the last count as a tick.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear of the count back to 0
//   tick - high for the one cycle the count equals DIV-1
module tick_div
    import led_pulse_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Free-running modulo-DIV count, restartable by clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == CW'(DIV - 1))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/led_pulse_gen.sv
// Stretches single-cycle event strobes into human-visible LED pulses with a
// forced gap between pulses; events arriving during a pulse are queued.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   ev_in   - event strobe, one event per high cycle
//   ovf_clr - synchronous clear of ovf
//   led     - registered LED drive, high while in ON
//   busy    - registered, high while a pulse is active or events are queued
//   pending - queued events not yet started
//   ovf     - sticky flag, set when an event is dropped on a full queue
module led_pulse_gen
    import led_pulse_pkg::*;
#(
    parameter int unsigned DIV       = DIV_DEF,
    parameter int unsigned ON_TICKS  = ON_TICKS_DEF,
    parameter int unsigned OFF_TICKS = OFF_TICKS_DEF,
    parameter int unsigned PEND_W    = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_in,
    input  logic              ovf_clr,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam int unsigned MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned PH_W  = $clog2(MAX_T + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [1:0]        state, state_nxt;
    logic [PH_W-1:0]   phase, phase_nxt;
    logic [PEND_W-1:0] pending_nxt;
    logic              ovf_nxt;
    logic              tick;
    logic              div_clr;
    logic              deq;
    logic              drop;

    tick_div #(.DIV(DIV)) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .tick (tick)
    );

    // State, queue and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
            led     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
            led     <= (state_nxt == ST_ON);
            busy    <= (state_nxt != ST_IDLE) || (pending_nxt != '0);
        end
    end

    // Next-state, dequeue and queue accounting
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        deq         = 1'b0;
        div_clr     = 1'b0;
        drop        = 1'b0;
        pending_nxt = pending;
        ovf_nxt     = ovf;

        case (state)
            ST_IDLE: begin
                // Divider parked at 0 so the first ON tick is a full period away
                div_clr = 1'b1;
                if (pending != '0) begin
                    deq       = 1'b1;
                    state_nxt = ST_ON;
                    phase_nxt = '0;
                end
            end
            ST_ON: begin
                if (tick) begin
                    if (phase == PH_W'(ON_TICKS - 1)) begin
                        state_nxt = ST_GAP;
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase + PH_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (phase == PH_W'(OFF_TICKS - 1)) begin
                        phase_nxt = '0;
                        if (pending != '0) begin
                            deq       = 1'b1;
                            div_clr   = 1'b1;
                            state_nxt = ST_ON;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        phase_nxt = phase + PH_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = '0;
            end
        endcase

        // An event and a dequeue in the same cycle cancel out, even when full
        if (ev_in && !deq) begin
            if (pending != PEND_MAX) begin
                pending_nxt = pending + PEND_W'(1);
            end else begin
                drop = 1'b1;
            end
        end else if (!ev_in && deq) begin
            pending_nxt = pending - PEND_W'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end
    end

endmodule

// File: doc/led_pulse_gen.md
LED_PULSE_GEN -- requirements
Module: led_pulse_gen

Interface
REQ-001 SHALL have parameter DIV, default 4: clk cycles per slow tick, legal range >=2.
REQ-002 SHALL have parameter ON_TICKS, default 2: slow ticks per visible on-pulse, legal range >=1.
REQ-003 SHALL have parameter OFF_TICKS, default 1: slow ticks of forced gap after each pulse, legal range >=1.
REQ-004 SHALL have parameter PEND_W, default 2: pending-event counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port ev_in, input, 1: single-cycle event strobe, one event per high cycle.
REQ-008 SHALL have port ovf_clr, input, 1: synchronous clear of ovf.
REQ-009 SHALL have port led, output, 1: registered human-visible pulse output.
REQ-010 SHALL have port busy, output, 1: high when state != IDLE or pending != 0.
REQ-011 SHALL have port pending, output, PEND_W: queued events not yet started.
REQ-012 SHALL have port ovf, output, 1: sticky flag for a dropped event.

Function
REQ-013 SHALL use a divider counting 0..DIV-1; tick is high for the one cycle where the divider equals DIV-1; the divider wraps to 0.
REQ-014 SHALL hold the divider at 0 in IDLE and clear it to 0 on every IDLE->ON and GAP->ON transition.
REQ-015 SHALL implement FSM states IDLE, ON and GAP.
REQ-016 SHALL transition IDLE->ON on any cycle with pending != 0, decrementing pending in that same cycle (dequeue).
REQ-017 SHALL hold ON for exactly ON_TICKS*DIV cycles, then transition to GAP.
REQ-018 SHALL hold GAP for exactly OFF_TICKS*DIV cycles, then go to ON with a dequeue if pending != 0, else to IDLE.
REQ-019 SHALL drive led = 1 exactly when the state is ON, as a register with no combinational path from ev_in.
REQ-020 SHALL fix latency so that an ev_in at cycle n, with IDLE and pending = 0, gives pending = 1 at n+1 and led = 1 at n+2.
REQ-021 SHALL increment pending on ev_in when pending < 2^PEND_W-1.
REQ-022 SHALL leave pending unchanged when ev_in and a dequeue occur in the same cycle, including when pending is full.
REQ-023 SHALL, on ev_in with pending full and no dequeue in that cycle, drop the event, leave pending saturated and set ovf on the next cycle.
REQ-024 SHALL clear ovf on ovf_clr, except that a set in the same cycle wins.
REQ-025 SHALL never let pending wrap past 0 or past its maximum.

Reset
REQ-026 SHALL, with rst high, immediately force state IDLE, led 0, pending 0, divider 0, tick-phase count 0, ovf 0 and busy 0.
REQ-027 SHALL discard any in-flight pulse or queued events on rst asserted mid-operation; no pulse resumes after release.
REQ-028 SHALL ignore ev_in while rst is high.

Structure
REQ-029 SHALL place the state enum (IDLE/ON/GAP) and the default parameter constants in shared package led_pulse_pkg.
REQ-030 SHALL implement the divider as sub-module tick_div (ports clk, rst, clr, tick).
REQ-031 SHALL keep the FSM, pending counter and ovf logic in led_pulse_gen.

Verification (DIV=4, ON_TICKS=2, OFF_TICKS=1, PEND_W=2)
REQ-032 SHALL cover a single event: ev_in at cycle 0 -> led high cycles 2..9, GAP cycles 10..13, busy low from cycle 14, ovf 0.
REQ-033 SHALL cover back-to-back events: ev_in at cycles 0,1,2 -> three 8-cycle led pulses starting at cycles 2, 14 and 26, each followed by a 4-cycle gap.
REQ-034 SHALL cover overflow: ev_in at cycles 0..4 -> pending goes 1,1,2,3 at cycles 1..4; ovf = 1 at cycle 5; exactly 4 pulses total.
REQ-035 SHALL cover a simultaneous event and dequeue: pending = 3 in GAP end cycle with ev_in high -> ON entered, pending stays 3, ovf stays 0.
REQ-036 SHALL cover reset mid-ON: rst pulsed at cycle 5 of the single-event test -> led 0 immediately, pending 0, no led activity for 40 cycles after release.
REQ-037 SHALL cover the ovf clear race: ovf_clr and an overflowing ev_in in the same cycle -> ovf remains 1; ovf_clr alone the next cycle -> ovf 0.
